// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between Execute and Writeback of the 16-bit core.
// Non-memory instructions retire one cycle after acceptance. LOAD/STORE go
// through a req/ack data-memory handshake, and upstream is stalled while the
// access is outstanding. Retired results are registered into the writeback
// pipeline register, and a wrapping retired-instruction counter is kept.
//
// Optional feature: define MEM_TIMEOUT_EN to enable an 8-bit access watchdog.
// When it is enabled, an access still unacknowledged after TIMEOUT_CYCLES
// cycles in ACCESS is aborted: the stage retires the instruction with data
// 16'hDEAD and sets the sticky mem_err flag. When it is not defined, ACCESS
// waits indefinitely for mem_ack and mem_err is tied low.
module memory_stage #(
    parameter int DATA_W         = 16,
    parameter int CTRL_W         = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] control_in,
    input  logic [4:0]        dest_index_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic              reg_write_en_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] wb_control,
    output logic [4:0]        wb_dest_index,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_reg_write_en,
    output logic [15:0]       instr_count,
    output logic              mem_err
);

    localparam logic [CTRL_W-1:0] OP_NOP   = CTRL_W'(5'b00000);
    localparam logic [CTRL_W-1:0] OP_LOAD  = CTRL_W'(5'b01100);
    localparam logic [CTRL_W-1:0] OP_STORE = CTRL_W'(5'b01110);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e            state_q;

    logic              memReq_q;
    logic              memWe_q;
    logic [DATA_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memWdata_q;

    // Instruction fields captured at accept, used when the access completes
    logic [CTRL_W-1:0] accCtrl_q;
    logic [4:0]        accDest_q;
    logic              accRegWe_q;

    logic              wbValid_q;
    logic [CTRL_W-1:0] wbControl_q;
    logic [4:0]        wbDest_q;
    logic [DATA_W-1:0] wbData_q;
    logic              wbRegWe_q;

    logic [15:0]       instrCount_q;
    logic [15:0]       instrCount_d;

    logic              isLoad;
    logic              isStore;
    logic              isNop;

    // Opcode decode of the incoming instruction
    always_comb begin
        isLoad  = (control_in == OP_LOAD);
        isStore = (control_in == OP_STORE);
        isNop   = (control_in == OP_NOP);
    end

    // Retire counter next value; natural 16-bit wrap FFFF -> 0000
    always_comb begin
        instrCount_d = instrCount_q + 16'd1;
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q;
    logic [7:0] wdog_d;
    logic       memErr_q;

    // Watchdog next value while waiting for an acknowledge
    always_comb begin
        wdog_d = wdog_q + 8'd1;
    end
`endif

    // Main FSM: accept, memory handshake, writeback register and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            memReq_q     <= 1'b0;
            memWe_q      <= 1'b0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            accCtrl_q    <= '0;
            accDest_q    <= '0;
            accRegWe_q   <= 1'b0;
            wbValid_q    <= 1'b0;
            wbControl_q  <= '0;
            wbDest_q     <= '0;
            wbData_q     <= '0;
            wbRegWe_q    <= 1'b0;
            instrCount_q <= '0;
`ifdef MEM_TIMEOUT_EN
            wdog_q       <= '0;
            memErr_q     <= 1'b0;
`endif
        end else begin
            wbValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (isLoad || isStore) begin
                            state_q    <= ACCESS;
                            memReq_q   <= 1'b1;
                            memWe_q    <= isStore;
                            memAddr_q  <= result_in;
                            memWdata_q <= store_data;
                            accCtrl_q  <= control_in;
                            accDest_q  <= dest_index_in;
                            accRegWe_q <= reg_write_en_in;
`ifdef MEM_TIMEOUT_EN
                            wdog_q     <= '0;
`endif
                        end else if (!isNop) begin
                            wbValid_q    <= 1'b1;
                            wbControl_q  <= control_in;
                            wbDest_q     <= dest_index_in;
                            wbData_q     <= result_in;
                            wbRegWe_q    <= reg_write_en_in;
                            instrCount_q <= instrCount_d;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state_q      <= IDLE;
                        memReq_q     <= 1'b0;
                        memWe_q      <= 1'b0;
                        wbValid_q    <= 1'b1;
                        wbControl_q  <= accCtrl_q;
                        wbDest_q     <= accDest_q;
                        wbData_q     <= memWe_q ? memAddr_q : mem_rdata;
                        wbRegWe_q    <= memWe_q ? 1'b0 : accRegWe_q;
                        instrCount_q <= instrCount_d;
`ifdef MEM_TIMEOUT_EN
                    end else if (wdog_q == WDOG_LAST) begin
                        state_q      <= IDLE;
                        memReq_q     <= 1'b0;
                        memWe_q      <= 1'b0;
                        wbValid_q    <= 1'b1;
                        wbControl_q  <= accCtrl_q;
                        wbDest_q     <= accDest_q;
                        wbData_q     <= DATA_W'(16'hDEAD);
                        wbRegWe_q    <= 1'b0;
                        instrCount_q <= instrCount_d;
                        memErr_q     <= 1'b1;
                    end else begin
                        wdog_q <= wdog_d;
`endif
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    memReq_q <= 1'b0;
                    memWe_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; stall depends on state only so it never loops back to Execute
    always_comb begin
        stall           = (state_q == ACCESS);
        mem_req         = memReq_q;
        mem_we          = memWe_q;
        mem_addr        = memAddr_q;
        mem_wdata       = memWdata_q;
        wb_valid        = wbValid_q;
        wb_control      = wbControl_q;
        wb_dest_index   = wbDest_q;
        wb_data         = wbData_q;
        wb_reg_write_en = wbRegWe_q;
        instr_count     = instrCount_q;
`ifdef MEM_TIMEOUT_EN
        mem_err         = memErr_q;
`else
        mem_err         = 1'b0;
`endif
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized self-checking bench for memory_stage.
// The reference model works at the transaction level. It tracks the expected
// writeback register contents, the retire count and the error flag, and it
// updates them once per retired instruction.
module tb_memory_stage;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b01100;
    localparam logic [4:0] OP_LOADI = 5'b01101;
    localparam logic [4:0] OP_STORE = 5'b01110;
`ifdef MEM_TIMEOUT_EN
    localparam int TO_CYCLES = 4;
`else
    localparam int TO_CYCLES = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  control_in;
    logic [4:0]  dest_index_in;
    logic [15:0] result_in;
    logic [15:0] store_data;
    logic        reg_write_en_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_control;
    logic [4:0]  wb_dest_index;
    logic [15:0] wb_data;
    logic        wb_reg_write_en;
    logic [15:0] instr_count;
    logic        mem_err;

    int checkCount;
    int passCount;

    // Reference model state
    logic [15:0] expData;
    logic [4:0]  expCtrl;
    logic [4:0]  expDest;
    logic        expRegWe;
    logic [15:0] expCount;
    logic        expErr;

    memory_stage #(
        .DATA_W(16),
        .CTRL_W(5),
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .control_in(control_in),
        .dest_index_in(dest_index_in),
        .result_in(result_in),
        .store_data(store_data),
        .reg_write_en_in(reg_write_en_in),
        .stall(stall),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .wb_valid(wb_valid),
        .wb_control(wb_control),
        .wb_dest_index(wb_dest_index),
        .wb_data(wb_data),
        .wb_reg_write_en(wb_reg_write_en),
        .instr_count(instr_count),
        .mem_err(mem_err)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic resetModel();
        expData  = '0;
        expCtrl  = '0;
        expDest  = '0;
        expRegWe = 1'b0;
        expCount = '0;
        expErr   = 1'b0;
    endtask

    task automatic retire(input logic [4:0] c, input logic [4:0] d,
                          input logic [15:0] v, input logic we);
        expCtrl  = c;
        expDest  = d;
        expData  = v;
        expRegWe = we;
        expCount = expCount + 16'd1;
    endtask

    // Checks the writeback side against the model after an edge
    task automatic checkWb(input string tag, input logic expValid);
        checkOutput({tag, ".wb_valid"}, 32'(wb_valid), 32'(expValid));
        checkOutput({tag, ".wb_data"}, 32'(wb_data), 32'(expData));
        checkOutput({tag, ".wb_control"}, 32'(wb_control), 32'(expCtrl));
        checkOutput({tag, ".wb_dest"}, 32'(wb_dest_index), 32'(expDest));
        checkOutput({tag, ".wb_rwe"}, 32'(wb_reg_write_en), 32'(expRegWe));
        checkOutput({tag, ".count"}, 32'(instr_count), 32'(expCount));
        checkOutput({tag, ".mem_err"}, 32'(mem_err), 32'(expErr));
    endtask

    // One non-memory instruction; retires on the next edge with no stall
    task automatic applyStimulus(input string tag, input logic [4:0] c, input logic [15:0] v,
                                 input logic [4:0] d, input logic we);
        in_valid        = 1'b1;
        control_in      = c;
        result_in       = v;
        dest_index_in   = d;
        reg_write_en_in = we;
        store_data      = 16'($urandom);
        mem_ack         = 1'($urandom_range(0, 1));
        mem_rdata       = 16'($urandom);
        @(posedge clk);
        #1;
        retire(c, d, v, we);
        checkWb(tag, 1'b1);
        checkOutput({tag, ".stall"}, 32'(stall), 32'd0);
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    endtask

    // Bubble cycle: a NOP or no valid input; nothing retires and wb fields hold
    task automatic applyIdle(input string tag, input bit asNop);
        in_valid        = asNop;
        control_in      = asNop ? OP_NOP : OP_LOAD;
        result_in       = 16'($urandom);
        dest_index_in   = 5'($urandom);
        reg_write_en_in = 1'b1;
        mem_ack         = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        checkWb(tag, 1'b0);
        checkOutput({tag, ".stall"}, 32'(stall), 32'd0);
    endtask

    // LOAD or STORE; ack arrives in ACCESS cycle nAcc, or never when doAck=0
    task automatic applyMem(input string tag, input bit st, input logic [15:0] addr,
                            input logic [15:0] wd, input logic [4:0] d, input logic we,
                            input int nAcc, input logic [15:0] rd, input bit doAck,
                            input bit holdAck);
        logic [4:0] op;
        op              = st ? OP_STORE : OP_LOAD;
        in_valid        = 1'b1;
        control_in      = op;
        result_in       = addr;
        store_data      = wd;
        dest_index_in   = d;
        reg_write_en_in = we;
        mem_ack         = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 1; c <= nAcc; c++) begin
            checkOutput({tag, ".stall"}, 32'(stall), 32'd1);
            checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'd1);
            checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
            checkOutput({tag, ".mem_we"}, 32'(mem_we), 32'(st));
            checkOutput({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wd));
            checkOutput({tag, ".busy_wb_valid"}, 32'(wb_valid), 32'd0);
            in_valid = 1'($urandom_range(0, 1));
            if (c == nAcc && doAck) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (doAck) begin
            retire(op, d, st ? addr : rd, st ? 1'b0 : we);
        end else begin
            retire(op, d, 16'hDEAD, 1'b0);
            expErr = 1'b1;
        end
        checkWb({tag, ".done"}, 1'b1);
        checkOutput({tag, ".done_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, ".done_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, ".done_we"}, 32'(mem_we), 32'd0);
        if (!holdAck) mem_ack = 1'b0;
        else begin
            @(posedge clk);
            #1;
            checkWb({tag, ".held_ack"}, 1'b0);
            checkOutput({tag, ".held_stall"}, 32'(stall), 32'd0);
            mem_ack = 1'b0;
        end
    endtask

    // Test sequence: directed cases from the plan, randomized traffic, reset and wrap
    initial begin
        int kind;
        int fillN;
        checkCount      = 0;
        passCount       = 0;
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        control_in      = OP_NOP;
        dest_index_in   = '0;
        result_in       = '0;
        store_data      = '0;
        reg_write_en_in = 1'b0;
        mem_rdata       = '0;
        mem_ack         = 1'b0;
        resetModel();

        #12;
        checkOutput("rst.stall", 32'(stall), 32'd0);
        checkOutput("rst.mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst.mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst.mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst.mem_we", 32'(mem_we), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkWb("post_rst", 1'b0);
        checkOutput("post_rst.mem_req", 32'(mem_req), 32'd0);

        applyStimulus("add15", OP_ADD, 16'd15, 5'd2, 1'b1);
        applyMem("load40", 1'b0, 16'h0040, 16'h0000, 5'd3, 1'b1, 3, 16'h1234, 1'b1, 1'b0);
        applyMem("store10", 1'b1, 16'h0010, 16'hBEEF, 5'd4, 1'b1, 1, 16'h5555, 1'b1, 1'b0);
        applyStimulus("add_after_store", OP_ADD, 16'h0077, 5'd5, 1'b1);
        applyStimulus("loadi", OP_LOADI, 16'hA5A5, 5'd6, 1'b1);
        applyIdle("nop", 1'b1);
        applyIdle("invalid", 1'b0);
        applyMem("load_heldack", 1'b0, 16'h0100, 16'h0000, 5'd7, 1'b1, 2, 16'h4321, 1'b1, 1'b1);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: begin
                    control_in = 5'($urandom);
                    if (control_in == OP_NOP || control_in == OP_LOAD || control_in == OP_STORE)
                        control_in = OP_LOADI;
                    applyStimulus("rnd_alu", control_in, 16'($urandom), 5'($urandom), 1'($urandom));
                end
                2: applyMem("rnd_load", 1'b0, 16'($urandom), 16'($urandom), 5'($urandom),
                            1'($urandom), $urandom_range(1, 3), 16'($urandom), 1'b1,
                            1'($urandom_range(0, 1)));
                3: applyMem("rnd_store", 1'b1, 16'($urandom), 16'($urandom), 5'($urandom),
                            1'($urandom), $urandom_range(1, 3), 16'($urandom), 1'b1,
                            1'($urandom_range(0, 1)));
                default: applyIdle("rnd_idle", 1'($urandom_range(0, 1)));
            endcase
        end

        // Reset asserted in the middle of an access cycle
        in_valid   = 1'b1;
        control_in = OP_LOAD;
        result_in  = 16'h0222;
        mem_ack    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst.req_before", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput("midrst.mem_req", 32'(mem_req), 32'd0);
        checkOutput("midrst.stall", 32'(stall), 32'd0);
        checkOutput("midrst.count", 32'(instr_count), 32'd0);
        checkOutput("midrst.wb_data", 32'(wb_data), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkWb("midrst.after", 1'b0);

        // Bring the counter up to FFFE with back-to-back ADDs, then watch it wrap
        fillN           = 32'(16'hFFFE - expCount);
        in_valid        = 1'b1;
        control_in      = OP_ADD;
        result_in       = 16'h0001;
        dest_index_in   = 5'd1;
        reg_write_en_in = 1'b1;
        mem_ack         = 1'b0;
        repeat (fillN) @(posedge clk);
        #1;
        expCount = 16'hFFFE;
        expCtrl  = OP_ADD;
        expDest  = 5'd1;
        expData  = 16'h0001;
        expRegWe = 1'b1;
        checkOutput("fill.count", 32'(instr_count), 32'hFFFE);
        applyStimulus("wrap0", OP_ADD, 16'h1111, 5'd8, 1'b1);
        checkOutput("wrap0.abs", 32'(instr_count), 32'hFFFF);
        applyStimulus("wrap1", OP_ADD, 16'h2222, 5'd9, 1'b0);
        checkOutput("wrap1.abs", 32'(instr_count), 32'h0000);
        applyStimulus("wrap2", OP_ADD, 16'h3333, 5'd10, 1'b1);
        checkOutput("wrap2.abs", 32'(instr_count), 32'h0001);
        applyIdle("wrap_nop", 1'b1);
        applyIdle("wrap_invalid", 1'b0);

`ifdef MEM_TIMEOUT_EN
        applyMem("timeout", 1'b0, 16'h0300, 16'h0000, 5'd11, 1'b1, TO_CYCLES, 16'h0, 1'b0, 1'b0);
        checkOutput("timeout.abs_data", 32'(wb_data), 32'hDEAD);
        applyMem("after_to", 1'b0, 16'h0304, 16'h0000, 5'd12, 1'b1, 2, 16'h6789, 1'b1, 1'b0);
        checkOutput("after_to.err", 32'(mem_err), 32'd1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
